// File: rtl/stack_cpu_pkg.sv
// -----------------------------------------------------------------------------
// stack_cpu_pkg
// Shared definitions for the stack CPU core: instruction field codes, the
// ALU operation encoding, the control FSM state type and a small decode helper.
// No ports; imported by stack_alu and stack_cpu_core.
// -----------------------------------------------------------------------------
package stack_cpu_pkg;

  // Major opcodes, taken from IR[15:12]
  localparam logic [3:0] OP_STACK  = 4'h0;
  localparam logic [3:0] OP_BRANCH = 4'h1;
  localparam logic [3:0] OP_BZ     = 4'h4;
  localparam logic [3:0] OP_BS     = 4'h8;
  localparam logic [3:0] OP_CALL   = 4'hE;
  localparam logic [3:0] OP_RET    = 4'hF;

  // Sub-codes under OP_STACK, taken from IR[11:8]; 8..F select an ALU op
  localparam logic [3:0] SUB_PUSH  = 4'h0;

  // ALU operation, taken from the low three bits of the sub-code
  typedef enum logic [2:0] {
    ALU_POP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_NEG = 3'd2,
    ALU_SUB = 3'd3,
    ALU_NOT = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  // Control FSM states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    STK_RD = 3'd2,
    STK_WR = 3'd3,
    EXEC   = 3'd4
  } state_e;

  // Branch/call offsets are 12-bit two's complement fields
  function automatic logic [15:0] signExt12(input logic [11:0] field);
    return {{4{field[11]}}, field};
  endfunction

  // Sub-codes 8..F under OP_STACK are the stack-operand ALU instructions
  function automatic logic isAluSub(input logic [3:0] sub);
    return sub[3];
  endfunction

endpackage

// File: rtl/stack_cpu_core_if.sv
// -----------------------------------------------------------------------------
// stack_cpu_core_if
// Memory bus between the stack CPU core and its memory.
//   MFC      memory-function-complete (read data valid / write done)
//   DataIn   read data from memory
//   AddrOut  memory address, registered by the core
//   DataOut  write data, registered by the core
//   RD / WR  read / write request levels, never high together
// Modports: master = CPU side, slave = memory side.
// -----------------------------------------------------------------------------
interface stack_cpu_core_if;

  logic        MFC;
  logic [15:0] DataIn;
  logic [15:0] AddrOut;
  logic [15:0] DataOut;
  logic        RD;
  logic        WR;

  modport master (
    input  MFC,
    input  DataIn,
    output AddrOut,
    output DataOut,
    output RD,
    output WR
  );

  modport slave (
    output MFC,
    output DataIn,
    input  AddrOut,
    input  DataOut,
    input  RD,
    input  WR
  );

endinterface

// File: rtl/stack_alu.sv
// -----------------------------------------------------------------------------
// stack_alu
// Purely combinational ALU for the stack CPU. Combines a register value with
// the operand popped off the stack.
//   rxVal_i    current value of the destination register rX
//   operand_i  value popped from the stack (v)
//   aluOp_i    operation select (ALOP)
//   result_o   16-bit result, wraps modulo 2^16
//   zero_o     result is zero
//   sign_o     result bit 15
// -----------------------------------------------------------------------------
module stack_alu
  import stack_cpu_pkg::*;
(
  input  logic [15:0] rxVal_i,
  input  logic [15:0] operand_i,
  input  alu_op_e     aluOp_i,
  output logic [15:0] result_o,
  output logic        zero_o,
  output logic        sign_o
);

  // Operation select. Pop, neg and not ignore rX entirely and only
  // transform the popped operand; the others combine both values.
  always_comb begin
    result_o = operand_i;
    case (aluOp_i)
      ALU_POP: result_o = operand_i;
      ALU_ADD: result_o = rxVal_i + operand_i;
      ALU_NEG: result_o = 16'h0000 - operand_i;
      ALU_SUB: result_o = rxVal_i - operand_i;
      ALU_NOT: result_o = ~operand_i;
      ALU_AND: result_o = rxVal_i & operand_i;
      ALU_OR:  result_o = rxVal_i | operand_i;
      ALU_XOR: result_o = rxVal_i ^ operand_i;
      default: result_o = operand_i;
    endcase
  end

  // Flag candidates; the core decides whether they are actually latched
  assign zero_o = (result_o == 16'h0000);
  assign sign_o = result_o[15];

endmodule

// File: rtl/stack_cpu_core.sv
// -----------------------------------------------------------------------------
// stack_cpu_core
// Small 16-bit stack machine: PC, SP, IR, sixteen 16-bit registers and Z/S
// flags, talking to memory over a level-based RD/WR + MFC handshake.
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    memory bus (stack_cpu_core_if, master side)
// Parameters:
//   RESET_PC  PC loaded at reset
//   RESET_SP  SP loaded at reset (stack grows downward, so the first push
//             lands at RESET_SP-1)
// -----------------------------------------------------------------------------
module stack_cpu_core
  import stack_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input logic              clk,
  input logic              reset,
  stack_cpu_core_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] ir_q, ir_d;
  logic        zFlag_q, zFlag_d;
  logic        sFlag_q, sFlag_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] operand_q, operand_d;

  logic [15:0] regFile_q [16];
  logic        rfWe;

  logic [3:0]  op;
  logic [3:0]  sub;
  logic [3:0]  rx;
  logic [15:0] offset;
  logic [15:0] target;
  logic [15:0] rxVal;
  alu_op_e     aluOp;
  logic [15:0] aluResult;
  logic        aluZero;
  logic        aluSign;

  // Instruction fields. pc_q already points past the instruction by the
  // time DECODE runs, so target is relative to the incremented PC.
  assign op     = ir_q[15:12];
  assign sub    = ir_q[11:8];
  assign rx     = ir_q[7:4];
  assign offset = signExt12(ir_q[11:0]);
  assign target = pc_q + offset;
  assign rxVal  = regFile_q[rx];
  assign aluOp  = alu_op_e'(sub[2:0]);

  stack_alu u_alu (
    .rxVal_i   (rxVal),
    .operand_i (operand_q),
    .aluOp_i   (aluOp),
    .result_o  (aluResult),
    .zero_o    (aluZero),
    .sign_o    (aluSign)
  );

  // Bus outputs come straight from registers so they are glitch-free and
  // held steady for the whole request.
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.AddrOut = addr_q;
  assign bus.DataOut = dout_q;

  // Next-state and datapath control. Every memory access follows the same
  // pattern: while idle, wait for MFC to be low (the previous access has
  // fully retired), then raise the request with the address; while the
  // request is up, wait for MFC high, consume the data and drop the request.
  // MFC is only looked at in the states that own an access.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ir_d      = ir_q;
    zFlag_d   = zFlag_q;
    sFlag_d   = sFlag_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    operand_d = operand_q;
    rfWe      = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!rd_q) begin
          if (!bus.MFC) begin
            rd_d   = 1'b1;
            addr_d = pc_q;
          end
        end else if (bus.MFC) begin
          rd_d    = 1'b0;
          ir_d    = bus.DataIn;
          pc_d    = pc_q + 16'd1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = FETCH;
        case (op)
          OP_STACK: begin
            if (sub == SUB_PUSH) begin
              sp_d    = sp_q - 16'd1;
              dout_d  = rxVal;
              state_d = STK_WR;
            end else if (isAluSub(sub)) begin
              state_d = STK_RD;
            end
          end
          OP_BRANCH: pc_d = target;
          OP_BZ: begin
            if (zFlag_q) begin
              pc_d = target;
            end
          end
          OP_BS: begin
            if (sFlag_q) begin
              pc_d = target;
            end
          end
          OP_CALL: begin
            sp_d    = sp_q - 16'd1;
            dout_d  = pc_q;
            state_d = STK_WR;
          end
          OP_RET: state_d = STK_RD;
          default: begin
          end
        endcase
      end

      STK_RD: begin
        if (!rd_q) begin
          if (!bus.MFC) begin
            rd_d   = 1'b1;
            addr_d = sp_q;
          end
        end else if (bus.MFC) begin
          rd_d = 1'b0;
          sp_d = sp_q + 16'd1;
          if (op == OP_RET) begin
            pc_d    = bus.DataIn;
            state_d = FETCH;
          end else begin
            operand_d = bus.DataIn;
            state_d   = EXEC;
          end
        end
      end

      STK_WR: begin
        if (!wr_q) begin
          if (!bus.MFC) begin
            wr_d   = 1'b1;
            addr_d = sp_q;
          end
        end else if (bus.MFC) begin
          wr_d    = 1'b0;
          state_d = FETCH;
          if (op == OP_CALL) begin
            pc_d = target;
          end
        end
      end

      EXEC: begin
        rfWe    = 1'b1;
        state_d = FETCH;
        if (aluOp != ALU_POP) begin
          zFlag_d = aluZero;
          sFlag_d = aluSign;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // Architectural and bus registers. Reset clears the request lines
  // asynchronously, which is what aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      sp_q      <= RESET_SP;
      ir_q      <= '0;
      zFlag_q   <= 1'b0;
      sFlag_q   <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      ir_q      <= ir_d;
      zFlag_q   <= zFlag_d;
      sFlag_q   <= sFlag_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      operand_q <= operand_d;
    end
  end

  // Register file. Only the EXEC state writes it, always to rX with the
  // ALU result, so a reset mid-instruction can never leave a partial update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (rfWe) begin
      regFile_q[rx] <= aluResult;
    end
  end

endmodule

// File: tb/tb_stack_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_stack_cpu_core
// Self-checking bench for stack_cpu_core. A behavioural memory answers RD/WR
// with MFC after a programmable latency. Two directed programs are run:
// program A (push/not/neg/pop/add, call/return and a countdown loop) at
// latencies 1 and 4 plus once with a reset pulse in the middle of a push,
// and program B (sub/and/or/xor, pop keeping flags, bz/bs, NOPs).
// -----------------------------------------------------------------------------
module tb_stack_cpu_core;

  localparam int FetchBudget = 6000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  stack_cpu_core_if bus ();

  stack_cpu_core #(
    .RESET_PC (16'h0000),
    .RESET_SP (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int          latency = 1;
  int          waitCount = 0;
  logic        bothSeen = 1'b0;
  logic        firstWrSeen = 1'b0;
  logic [15:0] firstWrAddr = 16'h0000;

  int          vectorCount = 0;
  int          missCount = 0;
  string       passName = "init";

  logic [15:0] progA [24] = '{
    16'h0000, 16'h0C00, 16'h0000, 16'h0A00,
    16'h0000, 16'h0000, 16'h0810, 16'h0910, 16'h0010, 16'h0010,
    16'h0000, 16'h0820, 16'h0920, 16'h0920,
    16'h0000, 16'h0A30, 16'hE054, 16'h8001, 16'h1FFD, 16'h1FFF,
    16'h0030, 16'h0920, 16'hF000, 16'h0000
  };

  logic [15:0] progB [26] = '{
    16'h0000, 16'h0C00, 16'h0000, 16'h0A10, 16'h0010, 16'h0910,
    16'h0010, 16'h0910, 16'h0010, 16'h0B00, 16'h0010, 16'h0D00,
    16'h4001, 16'h1FFF, 16'h0010, 16'h0E00, 16'h0010, 16'h0F00,
    16'h0010, 16'h0860, 16'h4001, 16'h1FFF, 16'h7123, 16'h0100,
    16'h8001, 16'h1FFF
  };

  // Memory model, evaluated on the falling edge so it never races the
  // core's rising-edge updates. A request is counted for 'latency' falling
  // edges, then served and MFC raised; MFC falls once the request drops.
  always @(negedge clk) begin
    if (bus.RD && bus.WR) begin
      bothSeen = 1'b1;
    end
    if (!reset) begin
      bus.MFC    = 1'b0;
      bus.DataIn = 16'h0000;
      waitCount  = 0;
    end else if (bus.RD || bus.WR) begin
      if (!bus.MFC) begin
        waitCount = waitCount + 1;
        if (waitCount >= latency) begin
          if (bus.RD) begin
            bus.DataIn = mem[bus.AddrOut];
          end else begin
            mem[bus.AddrOut] = bus.DataOut;
            if (!firstWrSeen) begin
              firstWrSeen = 1'b1;
              firstWrAddr = bus.AddrOut;
            end
          end
          bus.MFC = 1'b1;
        end
      end
    end else begin
      bus.MFC   = 1'b0;
      waitCount = 0;
    end
  end

  // Single comparison point: counts every vector, reports any miscompare.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s/%s: got %h, want %h", passName, tag, observed, expected);
    end
  endtask

  // Loads a program, sets the memory latency and pulses reset; returns on
  // the falling edge where reset is released.
  task automatic applyStimulus(input string name, input int which, input int lat);
    passName = name;
    reset = 1'b0;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'h0000;
    end
    if (which == 0) begin
      for (int a = 0; a < 20; a++) mem[a] = progA[a];
      for (int a = 0; a < 4; a++) mem[101 + a] = progA[20 + a];
    end else begin
      for (int a = 0; a < 26; a++) mem[a] = progB[a];
    end
    latency     = lat;
    bothSeen    = 1'b0;
    firstWrSeen = 1'b0;
    firstWrAddr = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for a fresh fetch request of 'addr'; a timeout is
  // reported as a miscompare on the 'reached' vector.
  task automatic waitFetch(input logic [15:0] addr, input string tag);
    int cycles;
    cycles = 0;
    while (bus.RD && bus.AddrOut == addr && cycles < FetchBudget) begin
      @(negedge clk);
      cycles++;
    end
    while (!(bus.RD && bus.AddrOut == addr) && cycles < FetchBudget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(tag, (cycles < FetchBudget) ? 16'd1 : 16'd0, 16'd1);
  endtask

  // Program A checkpoints, each taken as the next instruction is fetched.
  task automatic checkProgramA();
    waitFetch(16'd4, "reach_4");
    checkOutput("r0_after_neg", dut.regFile_q[0], 16'h0001);
    checkOutput("mem_ffff_not", mem[16'hFFFF], 16'hFFFF);
    checkOutput("sp_after_a1", dut.sp_q, 16'h0000);
    checkOutput("first_push_addr", firstWrAddr, 16'hFFFF);
    waitFetch(16'd14, "reach_14");
    checkOutput("r1_add", dut.regFile_q[1], 16'h0002);
    checkOutput("r2_add", dut.regFile_q[2], 16'h0005);
    checkOutput("sp_after_a2", dut.sp_q, 16'h0000);
    waitFetch(16'd16, "reach_16");
    checkOutput("r3_neg", dut.regFile_q[3], 16'hFFFF);
    waitFetch(16'd101, "reach_101");
    checkOutput("call_ret_addr", mem[16'hFFFF], 16'd17);
    checkOutput("call_pc", dut.pc_q, 16'd101);
    checkOutput("call_sp", dut.sp_q, 16'hFFFF);
    waitFetch(16'd17, "reach_17");
    checkOutput("ret_pc", dut.pc_q, 16'd17);
    checkOutput("ret_sp", dut.sp_q, 16'h0000);
    waitFetch(16'd19, "reach_halt");
    waitFetch(16'd19, "halt_cycles");
    checkOutput("halt_pc", dut.pc_q, 16'd19);
    checkOutput("final_r2", dut.regFile_q[2], 16'hFFFF);
    checkOutput("final_s", {15'b0, dut.sFlag_q}, 16'h0001);
    checkOutput("final_z", {15'b0, dut.zFlag_q}, 16'h0000);
    checkOutput("final_sp", dut.sp_q, 16'h0000);
    checkOutput("final_r0", dut.regFile_q[0], 16'h0001);
    checkOutput("final_r3", dut.regFile_q[3], 16'hFFFF);
    checkOutput("rd_wr_exclusive", {15'b0, bothSeen}, 16'h0000);
  endtask

  initial begin
    logic [15:0] regOr;
    int          cycles;

    // Reset state while reset is held low
    repeat (2) @(negedge clk);
    checkOutput("rst_rd", {15'b0, bus.RD}, 16'h0000);
    checkOutput("rst_wr", {15'b0, bus.WR}, 16'h0000);
    checkOutput("rst_pc", dut.pc_q, 16'h0000);
    checkOutput("rst_sp", dut.sp_q, 16'h0000);
    checkOutput("rst_addr", bus.AddrOut, 16'h0000);
    checkOutput("rst_dout", bus.DataOut, 16'h0000);
    checkOutput("rst_ir", dut.ir_q, 16'h0000);

    applyStimulus("progA_n1", 0, 1);
    checkProgramA();

    applyStimulus("progA_n4", 0, 4);
    checkProgramA();

    // Abort the second push (r0 = FFFF written to FFFF) mid-handshake
    applyStimulus("progA_rst", 0, 4);
    cycles = 0;
    while (!(bus.WR && bus.DataOut == 16'hFFFF) && cycles < FetchBudget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reach_push_wr", (cycles < FetchBudget) ? 16'd1 : 16'd0, 16'd1);
    reset = 1'b0;
    #1;
    regOr = 16'h0000;
    for (int r = 0; r < 16; r++) begin
      regOr = regOr | dut.regFile_q[r];
    end
    checkOutput("abort_rd", {15'b0, bus.RD}, 16'h0000);
    checkOutput("abort_wr", {15'b0, bus.WR}, 16'h0000);
    checkOutput("abort_regs", regOr, 16'h0000);
    checkOutput("abort_pc", dut.pc_q, 16'h0000);
    checkOutput("abort_sp", dut.sp_q, 16'h0000);
    checkOutput("abort_addr", bus.AddrOut, 16'h0000);
    checkOutput("abort_dout", bus.DataOut, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    firstWrSeen = 1'b0;
    checkProgramA();

    // Program B: remaining ALU ops, pop preserving flags, bz/bs, NOPs
    applyStimulus("progB_n2", 1, 2);
    waitFetch(16'd10, "reach_10");
    checkOutput("sub_r0", dut.regFile_q[0], 16'hFFFB);
    checkOutput("sub_s", {15'b0, dut.sFlag_q}, 16'h0001);
    waitFetch(16'd12, "reach_12");
    checkOutput("and_r0", dut.regFile_q[0], 16'h0000);
    checkOutput("and_z", {15'b0, dut.zFlag_q}, 16'h0001);
    waitFetch(16'd16, "reach_16b");
    checkOutput("or_r0", dut.regFile_q[0], 16'h0004);
    checkOutput("or_z", {15'b0, dut.zFlag_q}, 16'h0000);
    waitFetch(16'd25, "reach_halt_b");
    waitFetch(16'd25, "halt_cycles_b");
    checkOutput("b_halt_pc", dut.pc_q, 16'd25);
    checkOutput("xor_r0", dut.regFile_q[0], 16'h0000);
    checkOutput("b_r1", dut.regFile_q[1], 16'h0004);
    checkOutput("pop_r6", dut.regFile_q[6], 16'h0004);
    checkOutput("pop_keeps_z", {15'b0, dut.zFlag_q}, 16'h0001);
    checkOutput("b_s", {15'b0, dut.sFlag_q}, 16'h0000);
    checkOutput("b_sp", dut.sp_q, 16'h0000);
    checkOutput("b_rd_wr_exclusive", {15'b0, bothSeen}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
